// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one 8-bit RAM port between the CPU (fetch/load/store) and the program
// loader/debug port. A winning request is latched, held on the RAM for
// WAIT_STATES+1 access cycles, then acknowledged with a one-cycle ack pulse.
//
// Handshake (both requesters): the requester raises req with we/addr/wdata and
// holds them stable until its ack pulses. The arbiter samples req only in IDLE.
// Once granted, the inputs are latched, so later changes (or req dropping) do
// not affect the transaction. A req still high during ACK is sampled again in
// the following IDLE cycle as a new request.
//
// Ports:
//   clk, reset                   clock, async active-high reset
//   cpu_req/we/addr/wdata        CPU request side
//   cpu_rdata, cpu_ack           CPU return side (rdata holds until next read)
//   ldr_req/we/addr/wdata        loader request side
//   ldr_rdata, ldr_ack           loader return side
//   ldr_hold                     blocks any new CPU grant while high
//   ram_addr, ram_wdata          latched address / write data to RAM
//   ram_rdata                    RAM read data
//   ram_ri, ram_ro               RAM write / read strobes (ACCESS only)
//   busy, owner                  transaction in flight / owner (0 CPU, 1 ldr)
//   dbg_state                    FSM state: 0 IDLE, 1 ACCESS, 2 ACK
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ack,
    input  logic       ldr_req,
    input  logic       ldr_we,
    input  logic [7:0] ldr_addr,
    input  logic [7:0] ldr_wdata,
    output logic [7:0] ldr_rdata,
    output logic       ldr_ack,
    input  logic       ldr_hold,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       ram_ri,
    output logic       ram_ro,
    output logic       busy,
    output logic       owner,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

    state_t     state;
    state_t     state_nx;
    logic [2:0] cnt;
    logic       we_q;
    logic       last_q;     // requester served last: 0 CPU, 1 loader
    logic       cpu_elig;
    logic       grant;
    logic       grant_ldr;
    logic       access_done;

    // Arbitration. On a tie the loader wins only if the CPU was served last;
    // last_q resets to loader so the CPU takes the first tie.
    always_comb begin
        cpu_elig    = cpu_req & ~ldr_hold;
        grant       = cpu_elig | ldr_req;
        grant_ldr   = ldr_req & (~cpu_elig | ~last_q);
        access_done = (state == ST_ACCESS) && (cnt == 3'd0);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (grant) state_nx = ST_ACCESS;
            ST_ACCESS: if (cnt == 3'd0) state_nx = ST_ACK;
            ST_ACK:    state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Output decode. Strobes come straight from the state register and the
    // latched we, so they are glitch-free and fall as soon as reset hits.
    always_comb begin
        ram_ri    = (state == ST_ACCESS) &  we_q;
        ram_ro    = (state == ST_ACCESS) & ~we_q;
        dbg_state = state;
    end

    // Datapath: request latch, wait counter, read capture, acks, status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 3'd0;
            we_q      <= 1'b0;
            last_q    <= 1'b1;
            ram_addr  <= 8'h00;
            ram_wdata <= 8'h00;
            owner     <= 1'b0;
            cpu_rdata <= 8'h00;
            ldr_rdata <= 8'h00;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            busy    <= (state_nx != ST_IDLE);
            // Acks are registered so they land exactly in the ACK cycle.
            cpu_ack <= access_done & ~owner;
            ldr_ack <= access_done &  owner;

            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        owner     <= grant_ldr;
                        we_q      <= grant_ldr ? ldr_we    : cpu_we;
                        ram_addr  <= grant_ldr ? ldr_addr  : cpu_addr;
                        ram_wdata <= grant_ldr ? ldr_wdata : cpu_wdata;
                        cnt       <= WAIT_INIT;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == 3'd0) begin
                        // Capture on the final ACCESS edge, into the owner only.
                        if (!we_q) begin
                            if (owner) ldr_rdata <= ram_rdata;
                            else       cpu_rdata <= ram_rdata;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_ACK: begin
                    last_q <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two instances share the request inputs: dut1 (WAIT_STATES=1) and dut0
// (WAIT_STATES=0). Each has its own small RAM model. Unwritten locations read
// as addr ^ 8'hB7 (so 0x12 reads 0xA5, 0x20 reads 0x97); writes are stored.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic       cpu_req, cpu_we, ldr_req, ldr_we, ldr_hold;
    logic [7:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;

    // ---------------- dut1 (WAIT_STATES = 1) ----------------
    logic [7:0] cpu_rdata_1, ldr_rdata_1, ram_addr_1, ram_wdata_1, ram_rdata_1;
    logic       cpu_ack_1, ldr_ack_1, ram_ri_1, ram_ro_1, busy_1, owner_1;
    logic [1:0] dbg_state_1;

    mem_arbiter #(.WAIT_STATES(1)) dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_1), .cpu_ack(cpu_ack_1),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata_1), .ldr_ack(ldr_ack_1), .ldr_hold(ldr_hold),
        .ram_addr(ram_addr_1), .ram_wdata(ram_wdata_1), .ram_rdata(ram_rdata_1),
        .ram_ri(ram_ri_1), .ram_ro(ram_ro_1), .busy(busy_1), .owner(owner_1),
        .dbg_state(dbg_state_1)
    );

    // ---------------- dut0 (WAIT_STATES = 0) ----------------
    logic [7:0] cpu_rdata_0, ldr_rdata_0, ram_addr_0, ram_wdata_0, ram_rdata_0;
    logic       cpu_ack_0, ldr_ack_0, ram_ri_0, ram_ro_0, busy_0, owner_0;
    logic [1:0] dbg_state_0;

    mem_arbiter #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_0), .cpu_ack(cpu_ack_0),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata_0), .ldr_ack(ldr_ack_0), .ldr_hold(ldr_hold),
        .ram_addr(ram_addr_0), .ram_wdata(ram_wdata_0), .ram_rdata(ram_rdata_0),
        .ram_ri(ram_ri_0), .ram_ro(ram_ro_0), .busy(busy_0), .owner(owner_0),
        .dbg_state(dbg_state_0)
    );

    // ---------------- RAM models ----------------
    logic [7:0]   mem1 [256];
    logic [7:0]   mem0 [256];
    logic [255:0] wr_valid_1, wr_valid_0;

    always @(posedge clk) begin
        if (reset) begin
            wr_valid_1 <= '0;
        end else if (ram_ri_1) begin
            mem1[ram_addr_1]       <= ram_wdata_1;
            wr_valid_1[ram_addr_1] <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            wr_valid_0 <= '0;
        end else if (ram_ri_0) begin
            mem0[ram_addr_0]       <= ram_wdata_0;
            wr_valid_0[ram_addr_0] <= 1'b1;
        end
    end

    assign ram_rdata_1 = wr_valid_1[ram_addr_1] ? mem1[ram_addr_1] : (ram_addr_1 ^ 8'hB7);
    assign ram_rdata_0 = wr_valid_0[ram_addr_0] ? mem0[ram_addr_0] : (ram_addr_0 ^ 8'hB7);

    // ---------------- scoreboard ----------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 8'h00; ldr_wdata = 8'h00;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int last_k;
        int n_acks;
        logic [7:0] e;

        reset    = 1'b1;
        ldr_hold = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;

        // Reset state and quiet idle
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_flags", {2'b00, busy_1, owner_1, cpu_ack_1, ldr_ack_1, ram_ri_1, ram_ro_1}, 8'h00);
            chk("idle_state", 8'(dbg_state_1), 8'd0);
        end
        chk("rst_ram_addr", ram_addr_1, 8'h00);
        chk("rst_ram_wdata", ram_wdata_1, 8'h00);
        chk("rst_cpu_rdata", cpu_rdata_1, 8'h00);
        chk("rst_ldr_rdata", ldr_rdata_1, 8'h00);

        // CPU read of 0x12 (RAM holds 0xA5)
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12;
        tick();  // cycle 1
        chk("rd_c1_ro", 8'(ram_ro_1), 8'd1);
        chk("rd_c1_ri", 8'(ram_ri_1), 8'd0);
        chk("rd_c1_addr", ram_addr_1, 8'h12);
        chk("rd_c1_busy_owner", {6'd0, busy_1, owner_1}, 8'b10);
        chk("rd_c1_state", 8'(dbg_state_1), 8'd1);
        tick();  // cycle 2
        chk("rd_c2_ro", 8'(ram_ro_1), 8'd1);
        chk("rd_c2_ack", 8'(cpu_ack_1), 8'd0);
        tick();  // cycle 3
        chk("rd_c3_ack", {6'd0, cpu_ack_1, ldr_ack_1}, 8'b10);
        chk("rd_c3_ro", 8'(ram_ro_1), 8'd0);
        chk("rd_c3_rdata", cpu_rdata_1, 8'hA5);
        chk("rd_c3_ldr_rdata", ldr_rdata_1, 8'h00);
        chk("rd_c3_state", 8'(dbg_state_1), 8'd2);
        cpu_req = 1'b0;
        tick();
        chk("rd_c4_ack", 8'(cpu_ack_1), 8'd0);
        chk("rd_c4_busy", 8'(busy_1), 8'd0);

        // Loader write of 0x3C to 0x80, then CPU read back
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h80; ldr_wdata = 8'h3C;
        tick();
        chk("wr_c1_ri_ro", {6'd0, ram_ri_1, ram_ro_1}, 8'b10);
        chk("wr_c1_addr", ram_addr_1, 8'h80);
        chk("wr_c1_wdata", ram_wdata_1, 8'h3C);
        chk("wr_c1_owner", 8'(owner_1), 8'd1);
        tick();
        chk("wr_c2_ri", 8'(ram_ri_1), 8'd1);
        tick();
        chk("wr_c3_acks", {6'd0, cpu_ack_1, ldr_ack_1}, 8'b01);
        chk("wr_c3_ri", 8'(ram_ri_1), 8'd0);
        chk("wr_c3_ldr_rdata", ldr_rdata_1, 8'h00);
        chk("wr_c3_cpu_rdata", cpu_rdata_1, 8'hA5);
        ldr_req = 1'b0; ldr_we = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h80;
        tick();
        tick();
        tick();
        chk("rb_ack", 8'(cpu_ack_1), 8'd1);
        chk("rb_rdata", cpu_rdata_1, 8'h3C);
        cpu_req = 1'b0;
        tick();

        // Both requesting continuously: round-robin, one ack every 4 cycles
        pulse_reset();
        cpu_req = 1'b1; cpu_addr = 8'h01;
        ldr_req = 1'b1; ldr_addr = 8'h02;
        exp_q.push_back(8'd0); exp_q.push_back(8'd1);
        exp_q.push_back(8'd0); exp_q.push_back(8'd1);
        last_k = -1;
        n_acks = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("rr_overlap", 8'(cpu_ack_1 & ldr_ack_1), 8'd0);
            if (cpu_ack_1 || ldr_ack_1) begin
                n_acks++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
                chk("rr_owner", 8'(ldr_ack_1), e);
                if (last_k >= 0) chk("rr_period", 8'(k - last_k), 8'd4);
                last_k = k;
            end
        end
        chk("rr_count", 8'(n_acks), 8'd4);
        chk("rr_q_empty", 8'(exp_q.size()), 8'd0);
        idle_inputs();
        tick();

        // ldr_hold blocks CPU; after hold drops the CPU goes next
        pulse_reset();
        ldr_hold = 1'b1;
        cpu_req = 1'b1; cpu_addr = 8'h05;
        ldr_req = 1'b1; ldr_addr = 8'h06;
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk("hold_cpu_ack", 8'(cpu_ack_1), 8'((k == 11) ? 1 : 0));
            chk("hold_ldr_ack", 8'(ldr_ack_1), 8'((k == 3 || k == 7) ? 1 : 0));
            if (k == 9) chk("hold_owner_cpu", 8'(owner_1), 8'd0);
            if (k == 7) ldr_hold = 1'b0;
        end
        idle_inputs();
        tick();

        // WAIT_STATES = 0: one ACCESS cycle, ack in cycle 2, address latched
        pulse_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
        tick();
        chk("ws0_c1_ro", 8'(ram_ro_0), 8'd1);
        chk("ws0_c1_addr", ram_addr_0, 8'h20);
        chk("ws0_c1_state", 8'(dbg_state_0), 8'd1);
        cpu_addr = 8'h77;
        tick();
        chk("ws0_c2_ack", 8'(cpu_ack_0), 8'd1);
        chk("ws0_c2_rdata", cpu_rdata_0, 8'h97);
        chk("ws0_c2_addr", ram_addr_0, 8'h20);
        chk("ws0_c2_ro", 8'(ram_ro_0), 8'd0);
        cpu_req = 1'b0;
        tick();
        chk("ws0_c3_ack", 8'(cpu_ack_0), 8'd0);
        chk("ws0_c3_busy", 8'(busy_0), 8'd0);

        // Async reset during ACCESS of a write: strobe drops with no edge, no ack
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 8'h99;
        tick();
        chk("ar_pre_ri", 8'(ram_ri_1), 8'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_ri_drop", 8'(ram_ri_1), 8'd0);
        chk("ar_busy_drop", 8'(busy_1), 8'd0);
        chk("ar_state", 8'(dbg_state_1), 8'd0);
        chk("ar_addr", ram_addr_1, 8'h00);
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ar_no_ack", {6'd0, cpu_ack_1, ldr_ack_1}, 8'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single 8-bit RAM port between two requesters: the CPU fetch/load/store path and a program loader/debug port. Each transaction is granted, then held for a programmable number of RAM access cycles, then acknowledged. Both sides use a req/ack handshake. The block sits between the CPU's MAR/bus interface, the loader, and the RAM, and drives the RAM's `ri`/`ro` strobes.

## Interface
Parameters:
- `WAIT_STATES`, default 1: extra RAM access cycles per transaction, legal range 0..7.

Ports:
- `clk` in 1: single system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `cpu_req` in 1: CPU requests one RAM transaction.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 8, `cpu_wdata` in 8: CPU address and write data.
- `cpu_rdata` out 8: last read data returned to the CPU.
- `cpu_ack` out 1: one-cycle completion pulse to the CPU.
- `ldr_req`, `ldr_we`, `ldr_addr`[8], `ldr_wdata`[8] in: loader equivalents of the CPU request inputs.
- `ldr_rdata` out 8, `ldr_ack` out 1: loader equivalents of the CPU return outputs.
- `ldr_hold` in 1: while high, the CPU is never granted.
- `ram_addr` out 8, `ram_wdata` out 8: RAM address and write data.
- `ram_rdata` in 8: RAM read data.
- `ram_ri` out 1: RAM write strobe.
- `ram_ro` out 1: RAM read strobe.
- `busy` out 1: high in ACCESS and ACK.
- `owner` out 1: 0 = CPU, 1 = loader; valid while `busy`.

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one eligible request: grant it.
  - Both eligible: round-robin. Grant the requester not served last. The `last` register resets to loader, so the CPU wins the first tie.
  - CPU eligibility = `cpu_req & !ldr_hold`.
- On grant, latch `we`, `addr` and `wdata` from the winner, set `owner`, load the wait counter with `WAIT_STATES`, and go to ACCESS.
- ACCESS:
  - `ram_addr`/`ram_wdata` come from the latched values.
  - `ram_ri = we`, `ram_ro = !we`, both held constant for the whole state.
  - Counter decrements each cycle. When the counter is 0, go to ACK; on that final ACCESS edge, a read captures `ram_rdata` into the owner's rdata register.
- ACK:
  - Owner's ack is high for exactly this one cycle. Strobes are low.
  - Update `last` to `owner`, then return to IDLE.
- Requesters keep `req` and their inputs stable until ack. Inputs changing after grant have no effect, because the values are latched.
- `req` dropped mid-transaction: the transaction still completes and ack still pulses.
- `req` still high in the ACK cycle is sampled in the following IDLE cycle as a new request.
- `cpu_rdata`/`ldr_rdata` hold their value until that port's next read completes. Writes never change them.
- `ldr_hold` rising during a CPU transaction does not abort it. It only blocks future CPU grants.
- Reset (async, any state):
  - FSM goes to IDLE, counter 0, `last` = loader.
  - All outputs 0: `ram_*`, acks, rdata, `busy`, `owner`.
  - Any in-flight transaction is abandoned with no ack. RAM strobes drop immediately, not at the next edge.

## Timing
- Cycle 0: arbiter in IDLE, request sampled, grant edge.
- Cycles 1..`WAIT_STATES`+1: ACCESS.
- Cycle `WAIT_STATES`+2: ACK.
- Latency from req seen to ack = `WAIT_STATES`+2 cycles. With `WAIT_STATES`=1, ack appears in cycle 3.
- Minimum transaction period = `WAIT_STATES`+3 cycles, since IDLE always lasts at least one cycle.
- `busy` goes high the cycle after the grant edge and drops the cycle after ACK.
- All outputs are registered except `ram_ri`/`ram_ro`, which decode from registered state and latched `we`. They are glitch-free.

## Test plan
- Reset released, no requests -> all outputs 0, `busy` 0 indefinitely. Assert reset in ACCESS of a write -> `ram_ri` drops without a clock edge and no `cpu_ack` occurs.
- `WAIT_STATES`=1; CPU read of `0x12`, RAM holds `0xA5` -> `ram_ro` high cycles 1-2, `cpu_ack` pulse cycle 3, `cpu_rdata` = `0xA5`, `ldr_rdata` unchanged.
- Loader write of `0x3C` to `0x80` -> `ram_ri` high for 2 cycles with `ram_addr` = `0x80`, `ram_wdata` = `0x3C`, then `ldr_ack`. A subsequent CPU read of `0x80` returns `0x3C`.
- Both requesting continuously -> grants alternate CPU, loader, CPU, loader, one ack every 4 cycles, never two acks in one cycle.
- `ldr_hold` high with both requesting -> only loader granted. Drop hold -> the CPU is granted next, since the loader was served last.
- `WAIT_STATES`=0 -> ACCESS lasts 1 cycle, ack in cycle 2. Change `cpu_addr` during ACCESS -> `ram_addr` stays at the latched value.
